// File: rtl/game_sequencer_if.sv
// Button/frame/collision inputs and status outputs of the breakout play sequencer.
// The master side drives the event inputs; the sequencer is the slave.
interface game_sequencer_if;
  logic       start;
  logic       pause;
  logic       frame_tick;
  logic       brick_hit;
  logic       ball_lost;
  logic [2:0] state;
  logic       ball_en;
  logic       ball_rst;
  logic       score_pulse;
  logic [1:0] lives;
  logic [3:0] bricks_left;
  logic       game_over;
  logic       win;

  modport master (
    output start, pause, frame_tick, brick_hit, ball_lost,
    input  state, ball_en, ball_rst, score_pulse, lives, bricks_left, game_over, win
  );

  modport slave (
    input  start, pause, frame_tick, brick_hit, ball_lost,
    output state, ball_en, ball_rst, score_pulse, lives, bricks_left, game_over, win
  );
endinterface

// File: rtl/game_sequencer.sv
// Breakout play sequencer: serve/play/life-lost/win/game-over flow with lives and brick tracking.
// Optional pause support is enabled by defining GAME_SEQUENCER_PAUSE_EN.
module game_sequencer #(
  parameter int LIVES        = 3,
  parameter int NUM_BRICKS   = 8,
  parameter int SERVE_FRAMES = 60
) (
  input logic              clk,
  input logic              rst_n,
  game_sequencer_if.slave  gs
);
  localparam int CW = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
  localparam logic [CW-1:0] SERVE_LOAD = CW'(SERVE_FRAMES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SERVE  = 3'd1,
    PLAY   = 3'd2,
    PAUSED = 3'd3,
    OVER   = 3'd4,
    WIN    = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    lives_q, lives_d;
  logic [3:0]    bricks_q, bricks_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          score_d;
  logic          start_q;
  logic          start_edge;
  logic          ball_en_q, ball_rst_q, score_q, game_over_q, win_q;

  assign start_edge = gs.start & ~start_q;

`ifdef GAME_SEQUENCER_PAUSE_EN
  logic pause_q;
  logic pause_edge;
  assign pause_edge = gs.pause & ~pause_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pause_q <= 1'b0;
    else        pause_q <= gs.pause;
  end
`else
  logic unused_pause;
  assign unused_pause = gs.pause;
`endif

  always_comb begin
    state_d  = state_q;
    lives_d  = lives_q;
    bricks_d = bricks_q;
    cnt_d    = cnt_q;
    score_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_edge) begin
          state_d = SERVE;
          cnt_d   = SERVE_LOAD;
        end
      end
      SERVE: begin
        if (gs.frame_tick) begin
          if (cnt_q != '0) cnt_d   = cnt_q - CW'(1);
          else             state_d = PLAY;
        end
      end
      PLAY: begin
        // The brick is scored first; a last-brick win suppresses a simultaneous life loss.
        if (gs.brick_hit && bricks_q != 4'd0) begin
          bricks_d = bricks_q - 4'd1;
          score_d  = 1'b1;
          if (bricks_q == 4'd1) state_d = WIN;
        end
        if (gs.ball_lost && state_d == PLAY && lives_q != 2'd0) begin
          lives_d = lives_q - 2'd1;
          if (lives_q == 2'd1) begin
            state_d = OVER;
          end else begin
            state_d = SERVE;
            cnt_d   = SERVE_LOAD;
          end
        end
`ifdef GAME_SEQUENCER_PAUSE_EN
        if (pause_edge && state_d == PLAY) state_d = PAUSED;
`endif
      end
      PAUSED: begin
`ifdef GAME_SEQUENCER_PAUSE_EN
        if (pause_edge) state_d = PLAY;
`endif
      end
      OVER, WIN: begin
        if (start_edge) begin
          state_d  = IDLE;
          lives_d  = 2'(LIVES);
          bricks_d = 4'(NUM_BRICKS);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lives_q     <= 2'(LIVES);
      bricks_q    <= 4'(NUM_BRICKS);
      cnt_q       <= '0;
      start_q     <= 1'b0;
      ball_en_q   <= 1'b0;
      ball_rst_q  <= 1'b1;
      score_q     <= 1'b0;
      game_over_q <= 1'b0;
      win_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      bricks_q    <= bricks_d;
      cnt_q       <= cnt_d;
      start_q     <= gs.start;
      ball_en_q   <= (state_d == PLAY);
      ball_rst_q  <= (state_d inside {IDLE, SERVE, OVER, WIN});
      score_q     <= score_d;
      game_over_q <= (state_d == OVER);
      win_q       <= (state_d == WIN);
    end
  end

  assign gs.state       = state_q;
  assign gs.lives       = lives_q;
  assign gs.bricks_left = bricks_q;
  assign gs.ball_en     = ball_en_q;
  assign gs.ball_rst    = ball_rst_q;
  assign gs.score_pulse = score_q;
  assign gs.game_over   = game_over_q;
  assign gs.win         = win_q;
endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer: directed scenarios plus randomized play against a game model.
module tb_game_sequencer;
  localparam int LIVES = 3;
  localparam int NB    = 8;
  localparam int SF    = 60;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  game_sequencer_if gs_if ();
  game_sequencer #(.LIVES(LIVES), .NUM_BRICKS(NB), .SERVE_FRAMES(SF)) dut (
    .clk(clk), .rst_n(rst_n), .gs(gs_if)
  );

  int total = 0;
  int bad   = 0;

  // game model: state codes as the visible state output
  int m_state, m_lives, m_bricks, m_wait;
  bit m_start_prev, m_pause_prev, m_score;

  function automatic void model_reset();
    m_state = 0; m_lives = LIVES; m_bricks = NB; m_wait = 0;
    m_start_prev = 0; m_pause_prev = 0; m_score = 0;
  endfunction

  function automatic void model_step(bit st, bit pa, bit ft, bit bh, bit bl);
    bit st_e, pa_e, settled;
    st_e = st && !m_start_prev;
    pa_e = pa && !m_pause_prev;
    m_start_prev = st;
    m_pause_prev = pa;
    m_score = 0;
    settled = 0;
    if (m_state == 0) begin
      if (st_e) begin m_state = 1; m_wait = SF; end
    end else if (m_state == 1) begin
      // m_wait counts frame ticks still required before launch
      if (ft) begin
        m_wait--;
        if (m_wait == 0) m_state = 2;
      end
    end else if (m_state == 2) begin
      if (bh && m_bricks > 0) begin
        m_bricks--; m_score = 1;
        if (m_bricks == 0) begin m_state = 5; settled = 1; end
      end
      if (!settled && bl) begin
        m_lives--;
        m_state = (m_lives == 0) ? 4 : 1;
        m_wait = SF;
        settled = 1;
      end
`ifdef GAME_SEQUENCER_PAUSE_EN
      if (!settled && pa_e) m_state = 3;
`endif
    end else if (m_state == 3) begin
`ifdef GAME_SEQUENCER_PAUSE_EN
      if (pa_e) m_state = 2;
`endif
    end else begin
      if (st_e) begin m_state = 0; m_lives = LIVES; m_bricks = NB; end
    end
  endfunction

  function automatic logic [13:0] model_vec();
    return {3'(m_state), (m_state == 2), (m_state != 2 && m_state != 3), m_score,
            2'(m_lives), 4'(m_bricks), (m_state == 4), (m_state == 5)};
  endfunction

  function automatic logic [13:0] dut_vec();
    return {gs_if.state, gs_if.ball_en, gs_if.ball_rst, gs_if.score_pulse,
            gs_if.lives, gs_if.bricks_left, gs_if.game_over, gs_if.win};
  endfunction

  task automatic cyc(input bit st, input bit pa, input bit ft, input bit bh, input bit bl);
    @(negedge clk);
    gs_if.start = st; gs_if.pause = pa; gs_if.frame_tick = ft;
    gs_if.brick_hit = bh; gs_if.ball_lost = bl;
    model_step(st, pa, ft, bh, bl);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    gs_if.start = 0; gs_if.pause = 0; gs_if.frame_tick = 0;
    gs_if.brick_hit = 0; gs_if.ball_lost = 0;
    rst_n = 0;
    model_reset();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 1, 0, 0);
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (dut_vec() !== 14'b000_0_1_0_11_1000_0_0) begin
      bad++; $display("FAIL reset_state got=%b want=%b", dut_vec(), 14'b000_0_1_0_11_1000_0_0);
    end
  endtask

  task automatic test_serve();
    do_reset();
    cyc(1, 0, 0, 0, 0);
    total++;
    if (gs_if.state !== 3'd1 || gs_if.ball_en !== 1'b0) begin
      bad++; $display("FAIL serve_enter state=%0d ball_en=%b want 1/0", gs_if.state, gs_if.ball_en);
    end
    for (int i = 1; i < SF; i++) begin
      cyc(0, 0, 1, 0, 0);
      cyc(0, 0, 0, 0, 0);
      total++;
      if (gs_if.state !== 3'd1 || gs_if.ball_en !== 1'b0) begin
        bad++; $display("FAIL serve_hold tick=%0d state=%0d ball_en=%b want 1/0", i, gs_if.state, gs_if.ball_en);
      end
    end
    cyc(0, 0, 1, 0, 0);
    total++;
    if (gs_if.state !== 3'd2 || gs_if.ball_en !== 1'b1 || gs_if.ball_rst !== 1'b0) begin
      bad++; $display("FAIL serve_launch state=%0d ball_en=%b ball_rst=%b want 2/1/0", gs_if.state, gs_if.ball_en, gs_if.ball_rst);
    end
  endtask

  task automatic test_bricks();
    for (int i = 0; i < NB; i++) begin
      cyc(0, 0, 0, 1, 0);
      total++;
      if (gs_if.score_pulse !== 1'b1 || gs_if.bricks_left !== 4'(NB - 1 - i)) begin
        bad++; $display("FAIL brick_hit n=%0d score=%b bricks=%0d want 1/%0d", i, gs_if.score_pulse, gs_if.bricks_left, NB - 1 - i);
      end
      cyc(0, 0, 0, 0, 0);
      total++;
      if (gs_if.score_pulse !== 1'b0) begin
        bad++; $display("FAIL score_width n=%0d score=%b want 0", i, gs_if.score_pulse);
      end
    end
    total++;
    if (gs_if.state !== 3'd5 || gs_if.win !== 1'b1 || gs_if.ball_en !== 1'b0) begin
      bad++; $display("FAIL win_state state=%0d win=%b ball_en=%b want 5/1/0", gs_if.state, gs_if.win, gs_if.ball_en);
    end
    cyc(0, 0, 0, 1, 0);
    total++;
    if (gs_if.bricks_left !== 4'd0 || gs_if.score_pulse !== 1'b0 || gs_if.state !== 3'd5) begin
      bad++; $display("FAIL win_frozen bricks=%0d score=%b state=%0d want 0/0/5", gs_if.bricks_left, gs_if.score_pulse, gs_if.state);
    end
  endtask

  task automatic test_lives();
    cyc(1, 0, 0, 0, 0);
    total++;
    if (gs_if.state !== 3'd0 || gs_if.lives !== 2'd3 || gs_if.bricks_left !== 4'd8 || gs_if.win !== 1'b0) begin
      bad++; $display("FAIL win_restart state=%0d lives=%0d bricks=%0d win=%b want 0/3/8/0", gs_if.state, gs_if.lives, gs_if.bricks_left, gs_if.win);
    end
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    ticks(SF);
    for (int i = 0; i < LIVES; i++) begin
      cyc(0, 0, 0, 0, 1);
      total++;
      if (i < LIVES - 1) begin
        if (gs_if.lives !== 2'(LIVES - 1 - i) || gs_if.state !== 3'd1 || gs_if.ball_rst !== 1'b1) begin
          bad++; $display("FAIL life_lost n=%0d lives=%0d state=%0d ball_rst=%b want %0d/1/1", i, gs_if.lives, gs_if.state, gs_if.ball_rst, LIVES - 1 - i);
        end
        ticks(SF);
      end else begin
        if (gs_if.lives !== 2'd0 || gs_if.state !== 3'd4 || gs_if.game_over !== 1'b1) begin
          bad++; $display("FAIL game_over lives=%0d state=%0d game_over=%b want 0/4/1", gs_if.lives, gs_if.state, gs_if.game_over);
        end
      end
    end
    cyc(0, 0, 0, 0, 1);
    total++;
    if (gs_if.lives !== 2'd0 || gs_if.state !== 3'd4) begin
      bad++; $display("FAIL over_frozen lives=%0d state=%0d want 0/4", gs_if.lives, gs_if.state);
    end
    cyc(1, 0, 0, 0, 0);
    total++;
    if (gs_if.state !== 3'd0 || gs_if.lives !== 2'd3 || gs_if.bricks_left !== 4'd8 || gs_if.game_over !== 1'b0) begin
      bad++; $display("FAIL over_restart state=%0d lives=%0d bricks=%0d game_over=%b want 0/3/8/0", gs_if.state, gs_if.lives, gs_if.bricks_left, gs_if.game_over);
    end
    cyc(1, 0, 0, 0, 0);
    total++;
    if (gs_if.state !== 3'd0) begin
      bad++; $display("FAIL held_start state=%0d want 0", gs_if.state);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    cyc(1, 0, 0, 0, 0);
    ticks(SF);
    cyc(0, 0, 0, 0, 1);
    ticks(SF);
    cyc(0, 0, 0, 0, 1);
    ticks(SF);
    for (int i = 0; i < NB - 1; i++) cyc(0, 0, 0, 1, 0);
    total++;
    if (gs_if.lives !== 2'd1 || gs_if.bricks_left !== 4'd1 || gs_if.state !== 3'd2) begin
      bad++; $display("FAIL simul_setup lives=%0d bricks=%0d state=%0d want 1/1/2", gs_if.lives, gs_if.bricks_left, gs_if.state);
    end
    cyc(0, 0, 0, 1, 1);
    total++;
    if (gs_if.state !== 3'd5 || gs_if.lives !== 2'd1 || gs_if.score_pulse !== 1'b1 || gs_if.bricks_left !== 4'd0) begin
      bad++; $display("FAIL simul_hit state=%0d lives=%0d score=%b bricks=%0d want 5/1/1/0", gs_if.state, gs_if.lives, gs_if.score_pulse, gs_if.bricks_left);
    end
    cyc(0, 0, 0, 0, 0);
    total++;
    if (gs_if.score_pulse !== 1'b0) begin
      bad++; $display("FAIL simul_single score=%b want 0", gs_if.score_pulse);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    cyc(1, 0, 0, 0, 0);
    ticks(SF);
    cyc(0, 0, 0, 1, 0);
    @(negedge clk);
    gs_if.brick_hit = 1;
    #2 rst_n = 0;
    #1;
    total++;
    if (dut_vec() !== 14'b000_0_1_0_11_1000_0_0) begin
      bad++; $display("FAIL async_reset got=%b want=%b", dut_vec(), 14'b000_0_1_0_11_1000_0_0);
    end
    @(posedge clk);
    #1;
    total++;
    if (gs_if.score_pulse !== 1'b0 || gs_if.bricks_left !== 4'd8) begin
      bad++; $display("FAIL reset_hold score=%b bricks=%0d want 0/8", gs_if.score_pulse, gs_if.bricks_left);
    end
    @(negedge clk);
    gs_if.brick_hit = 0;
    rst_n = 1;
    model_reset();
    cyc(0, 0, 0, 0, 0);
    total++;
    if (gs_if.state !== 3'd0 || gs_if.ball_rst !== 1'b1) begin
      bad++; $display("FAIL reset_release state=%0d ball_rst=%b want 0/1", gs_if.state, gs_if.ball_rst);
    end
  endtask

  task automatic test_pause();
    do_reset();
    cyc(1, 0, 0, 0, 0);
    ticks(SF);
`ifdef GAME_SEQUENCER_PAUSE_EN
    cyc(0, 1, 0, 0, 0);
    total++;
    if (gs_if.state !== 3'd3 || gs_if.ball_en !== 1'b0 || gs_if.ball_rst !== 1'b0) begin
      bad++; $display("FAIL pause_enter state=%0d ball_en=%b ball_rst=%b want 3/0/0", gs_if.state, gs_if.ball_en, gs_if.ball_rst);
    end
    cyc(0, 1, 0, 1, 1);
    total++;
    if (gs_if.state !== 3'd3 || gs_if.bricks_left !== 4'd8 || gs_if.lives !== 2'd3 || gs_if.score_pulse !== 1'b0) begin
      bad++; $display("FAIL pause_frozen state=%0d bricks=%0d lives=%0d score=%b want 3/8/3/0", gs_if.state, gs_if.bricks_left, gs_if.lives, gs_if.score_pulse);
    end
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    total++;
    if (gs_if.state !== 3'd2 || gs_if.ball_en !== 1'b1) begin
      bad++; $display("FAIL pause_resume state=%0d ball_en=%b want 2/1", gs_if.state, gs_if.ball_en);
    end
`else
    cyc(0, 1, 0, 0, 0);
    total++;
    if (gs_if.state !== 3'd2 || gs_if.ball_en !== 1'b1) begin
      bad++; $display("FAIL pause_ignored state=%0d ball_en=%b want 2/1", gs_if.state, gs_if.ball_en);
    end
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 0);
    total++;
    if (gs_if.state !== 3'd2 || gs_if.bricks_left !== 4'd7 || gs_if.score_pulse !== 1'b1) begin
      bad++; $display("FAIL pause_ignored_hit state=%0d bricks=%0d score=%b want 2/7/1", gs_if.state, gs_if.bricks_left, gs_if.score_pulse);
    end
`endif
  endtask

  task automatic test_random();
    bit st, pa;
    int errs;
    st = 0; pa = 0; errs = 0;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 9) == 0) st = ~st;
      if ($urandom_range(0, 9) == 0) pa = ~pa;
      cyc(st, pa, ($urandom_range(0, 1) == 1), ($urandom_range(0, 6) == 0), ($urandom_range(0, 24) == 0));
      total++;
      if (dut_vec() !== model_vec()) begin
        bad++;
        errs++;
        if (errs <= 10) $display("FAIL random cycle=%0d got=%b want=%b", i, dut_vec(), model_vec());
      end
    end
  endtask

  initial begin
    rst_n = 0;
    gs_if.start = 0; gs_if.pause = 0; gs_if.frame_tick = 0;
    gs_if.brick_hit = 0; gs_if.ball_lost = 0;
    test_reset();
    test_serve();
    test_bricks();
    test_lives();
    test_simultaneous();
    test_async_reset();
    test_pause();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
